cache_ram_bridge: RTL and testbench

- Sits directly downstream of the cache controller, between the I/D caches and the word-wide main RAM.
- Converts the controller's line-level request (enable_cache_to_ram, write_cache_to_ram, addr_cache_to_ram_ctr) into a burst of single-word RAM accesses: write-back of a dirty line, or refill of a missing line.
- Returns a one-cycle response_ram_to_cache pulse when the whole line is done. This pulse is what advances the controller out of its WRITE_BACK and REFILL states.

---
 rtl/cache_ram_bridge_if.sv | 39 +++
 rtl/cache_ram_bridge.sv | 150 +++++++++++++++
 tb/tb_cache_ram_bridge.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ram_bridge_if.sv
// Cache-controller / main-RAM bus bundle seen by cache_ram_bridge.
interface cache_ram_bridge_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned WORDS  = 4
);
    // Cache-controller side
    logic                       enable_cache_to_ram;
    logic                       write_cache_to_ram;
    logic                       addr_cache_to_ram_ctr;
    logic [ADDR_W-1:0]          wb_addr;
    logic [ADDR_W-1:0]          refill_addr;
    logic [WORDS*WORD_W-1:0]    line_wdata;
    logic [WORDS*WORD_W-1:0]    line_rdata;
    logic                       response_ram_to_cache;
    logic                       bridge_busy;
    // RAM side
    logic                       ram_en;
    logic                       ram_we;
    logic [ADDR_W-1:0]          ram_addr;
    logic [WORD_W-1:0]          ram_wdata;
    logic [WORD_W-1:0]          ram_rdata;

    // Environment: cache controller plus RAM
    modport master (
        output enable_cache_to_ram, write_cache_to_ram, addr_cache_to_ram_ctr,
        output wb_addr, refill_addr, line_wdata, ram_rdata,
        input  line_rdata, response_ram_to_cache, bridge_busy,
        input  ram_en, ram_we, ram_addr, ram_wdata
    );

    // The bridge itself
    modport slave (
        input  enable_cache_to_ram, write_cache_to_ram, addr_cache_to_ram_ctr,
        input  wb_addr, refill_addr, line_wdata, ram_rdata,
        output line_rdata, response_ram_to_cache, bridge_busy,
        output ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/cache_ram_bridge.sv
// Turns a line-level cache request into a burst of word RAM accesses
// (write-back of a dirty line or refill of a missing one) and pulses
// response_ram_to_cache once the whole line is done.
module cache_ram_bridge #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned WORD_W  = 32,
    parameter int unsigned WORDS   = 4,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    cache_ram_bridge_if.slave bus
);
    localparam int unsigned BYTES  = WORD_W / 8;
    localparam int unsigned BEAT_W = $clog2(WORDS);
    localparam int unsigned OFF_W  = $clog2(WORDS * BYTES);
    localparam int unsigned LINE_W = WORDS * WORD_W;

    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_RD, DONE} state_t;

    state_t              state_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [BEAT_W-1:0]   rcv_q;
    logic [LINE_W-1:0]   wdata_sr_q;
    logic [LINE_W-1:0]   line_rdata_q;
    logic [RAM_LAT-1:0]  vld_q;
    logic                ram_en_q;
    logic                ram_we_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [WORD_W-1:0]   ram_wdata_q;
    logic                resp_q;
    logic                busy_q;

    logic [ADDR_W-1:0]   base_d;
    logic [ADDR_W-1:0]   next_addr_d;
    logic [RAM_LAT-1:0]  vld_d;
    logic                rd_ret_d;
    logic                last_beat_d;
    logic                last_rcv_d;

    // Line-aligned base, next beat address, read-return pipeline and end-of-line flags
    always_comb begin
        base_d              = bus.addr_cache_to_ram_ctr ? bus.refill_addr : bus.wb_addr;
        base_d[OFF_W-1:0]   = '0;
        next_addr_d         = ram_addr_q + ADDR_W'(BYTES);
        vld_d               = vld_q << 1;
        vld_d[0]            = ram_en_q & ~ram_we_q;
        rd_ret_d            = vld_q[RAM_LAT-1] & ((state_q == READ) || (state_q == WAIT_RD));
        last_beat_d         = (beat_q == BEAT_W'(WORDS - 1));
        last_rcv_d          = (rcv_q == BEAT_W'(WORDS - 1));
    end

    // Burst FSM with registered RAM strobes, read-data capture and completion pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            rcv_q        <= '0;
            wdata_sr_q   <= '0;
            line_rdata_q <= '0;
            vld_q        <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            resp_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            resp_q <= 1'b0;

            // Returning read beats land in slot rcv, in issue order
            if (rd_ret_d) begin
                for (int unsigned i = 0; i < WORDS; i++) begin
                    if (rcv_q == BEAT_W'(i)) begin
                        line_rdata_q[i*WORD_W +: WORD_W] <= bus.ram_rdata;
                    end
                end
                rcv_q <= rcv_q + BEAT_W'(1);
            end

            unique case (state_q)
                IDLE: begin
                    if (bus.enable_cache_to_ram) begin
                        state_q    <= bus.write_cache_to_ram ? WRITE : READ;
                        busy_q     <= 1'b1;
                        beat_q     <= '0;
                        rcv_q      <= '0;
                        ram_en_q   <= 1'b1;
                        ram_we_q   <= bus.write_cache_to_ram;
                        ram_addr_q <= base_d;
                        if (bus.write_cache_to_ram) begin
                            ram_wdata_q <= bus.line_wdata[WORD_W-1:0];
                            wdata_sr_q  <= bus.line_wdata >> WORD_W;
                        end
                    end
                end
                WRITE: begin
                    if (last_beat_d) begin
                        state_q     <= DONE;
                        resp_q      <= 1'b1;
                        ram_en_q    <= 1'b0;
                        ram_we_q    <= 1'b0;
                        ram_addr_q  <= '0;
                        ram_wdata_q <= '0;
                    end else begin
                        beat_q      <= beat_q + BEAT_W'(1);
                        ram_addr_q  <= next_addr_d;
                        ram_wdata_q <= wdata_sr_q[WORD_W-1:0];
                        wdata_sr_q  <= wdata_sr_q >> WORD_W;
                    end
                end
                READ: begin
                    if (last_beat_d) begin
                        state_q    <= WAIT_RD;
                        ram_en_q   <= 1'b0;
                        ram_addr_q <= '0;
                    end else begin
                        beat_q     <= beat_q + BEAT_W'(1);
                        ram_addr_q <= next_addr_d;
                    end
                end
                WAIT_RD: begin
                    // The final beat always returns after issue has finished
                    if (rd_ret_d && last_rcv_d) begin
                        state_q <= DONE;
                        resp_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.line_rdata            = line_rdata_q;
    assign bus.response_ram_to_cache = resp_q;
    assign bus.bridge_busy           = busy_q;
    assign bus.ram_en                = ram_en_q;
    assign bus.ram_we                = ram_we_q;
    assign bus.ram_addr              = ram_addr_q;
    assign bus.ram_wdata             = ram_wdata_q;

endmodule

// File: tb/tb_cache_ram_bridge.sv
// Directed bench for cache_ram_bridge: one RAM_LAT=1 and one RAM_LAT=3 instance,
// each with a RAM model that returns addr ^ 0xFFFF.
module tb_cache_ram_bridge;
    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    cache_ram_bridge_if #(.ADDR_W(32), .WORD_W(32), .WORDS(4)) bus1 ();
    cache_ram_bridge_if #(.ADDR_W(32), .WORD_W(32), .WORDS(4)) bus3 ();

    cache_ram_bridge #(.ADDR_W(32), .WORD_W(32), .WORDS(4), .RAM_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    cache_ram_bridge #(.ADDR_W(32), .WORD_W(32), .WORDS(4), .RAM_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: non-read cycles return a poison word
    logic [31:0] pipe1;
    logic [31:0] pipe3 [3];
    always @(posedge clk) begin
        pipe1 <= (bus1.ram_en && !bus1.ram_we) ? (bus1.ram_addr ^ 32'h0000_FFFF) : 32'hDEAD_BEEF;
    end
    always @(posedge clk) begin
        pipe3[0] <= (bus3.ram_en && !bus3.ram_we) ? (bus3.ram_addr ^ 32'h0000_FFFF) : 32'hDEAD_BEEF;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign bus1.ram_rdata = pipe1;
    assign bus3.ram_rdata = pipe3[2];

    task automatic idle_inputs();
        bus1.enable_cache_to_ram   = 1'b0;
        bus1.write_cache_to_ram    = 1'b0;
        bus1.addr_cache_to_ram_ctr = 1'b0;
        bus1.wb_addr               = '0;
        bus1.refill_addr           = '0;
        bus1.line_wdata            = '0;
        bus3.enable_cache_to_ram   = 1'b0;
        bus3.write_cache_to_ram    = 1'b0;
        bus3.addr_cache_to_ram_ctr = 1'b0;
        bus3.wb_addr               = '0;
        bus3.refill_addr           = '0;
        bus3.line_wdata            = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        nvec++;
        if ({bus1.ram_en, bus1.ram_we, bus1.response_ram_to_cache, bus1.bridge_busy} !== 4'b0000) begin
            nerr++;
            $display("FAIL reset_ctrl: en/we/resp/busy=%b want 0000",
                     {bus1.ram_en, bus1.ram_we, bus1.response_ram_to_cache, bus1.bridge_busy});
        end
        nvec++;
        if ({bus1.ram_addr, bus1.ram_wdata} !== 64'h0) begin
            nerr++;
            $display("FAIL reset_bus: addr=%h wdata=%h want 0", bus1.ram_addr, bus1.ram_wdata);
        end
        nvec++;
        if (bus1.line_rdata !== 128'h0) begin
            nerr++;
            $display("FAIL reset_line: line_rdata=%h want 0", bus1.line_rdata);
        end
        nvec++;
        if ({bus3.ram_en, bus3.response_ram_to_cache, bus3.bridge_busy} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_lat3: en/resp/busy=%b want 000",
                     {bus3.ram_en, bus3.response_ram_to_cache, bus3.bridge_busy});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_back();
        logic        e_en;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        @(negedge clk);
        bus1.enable_cache_to_ram   = 1'b1;
        bus1.write_cache_to_ram    = 1'b1;
        bus1.addr_cache_to_ram_ctr = 1'b0;
        bus1.wb_addr               = 32'h0000_1234;
        bus1.refill_addr           = 32'h0000_7770;
        bus1.line_wdata            = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            e_en   = (k <= 4);
            e_addr = e_en ? 32'h0000_1230 + 32'(4 * (k - 1)) : 32'h0;
            e_wd   = e_en ? 32'hA0 + 32'(k - 1) : 32'h0;
            nvec++;
            if ({bus1.ram_en, bus1.ram_we, bus1.ram_addr, bus1.ram_wdata,
                 bus1.response_ram_to_cache, bus1.bridge_busy} !==
                {e_en, e_en, e_addr, e_wd, 1'(k == 5), 1'(k <= 5)}) begin
                nerr++;
                $display("FAIL write_back c%0d: en=%b we=%b addr=%h wd=%h resp=%b busy=%b want en=%b addr=%h wd=%h resp=%b busy=%b",
                         k, bus1.ram_en, bus1.ram_we, bus1.ram_addr, bus1.ram_wdata,
                         bus1.response_ram_to_cache, bus1.bridge_busy,
                         e_en, e_addr, e_wd, 1'(k == 5), 1'(k <= 5));
            end
            if (k == 5) bus1.enable_cache_to_ram = 1'b0;
        end
    endtask

    task automatic test_refill();
        logic        e_en;
        logic [31:0] e_addr;
        @(negedge clk);
        bus1.enable_cache_to_ram   = 1'b1;
        bus1.write_cache_to_ram    = 1'b0;
        bus1.addr_cache_to_ram_ctr = 1'b1;
        bus1.wb_addr               = 32'h0000_9990;
        bus1.refill_addr           = 32'h0000_2008;
        bus1.line_wdata            = {4{32'h5555_5555}};
        @(posedge clk);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            e_en   = (k <= 4);
            e_addr = e_en ? 32'h0000_2000 + 32'(4 * (k - 1)) : 32'h0;
            nvec++;
            if ({bus1.ram_en, bus1.ram_we, bus1.ram_addr, bus1.ram_wdata,
                 bus1.response_ram_to_cache, bus1.bridge_busy} !==
                {e_en, 1'b0, e_addr, 32'h0, 1'(k == 6), 1'(k <= 6)}) begin
                nerr++;
                $display("FAIL refill c%0d: en=%b we=%b addr=%h wd=%h resp=%b busy=%b want en=%b we=0 addr=%h resp=%b busy=%b",
                         k, bus1.ram_en, bus1.ram_we, bus1.ram_addr, bus1.ram_wdata,
                         bus1.response_ram_to_cache, bus1.bridge_busy,
                         e_en, e_addr, 1'(k == 6), 1'(k <= 6));
            end
            if (k >= 6) begin
                nvec++;
                if (bus1.line_rdata !== {32'h0000_DFF3, 32'h0000_DFF7, 32'h0000_DFFB, 32'h0000_DFFF}) begin
                    nerr++;
                    $display("FAIL refill_line c%0d: line_rdata=%h want 0000dff30000dff70000dffb0000dfff",
                             k, bus1.line_rdata);
                end
            end
            if (k == 6) bus1.enable_cache_to_ram = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic        e_en;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_resp;
        logic        e_busy;
        int          resp_cnt;
        resp_cnt = 0;
        @(negedge clk);
        bus1.enable_cache_to_ram   = 1'b1;
        bus1.write_cache_to_ram    = 1'b1;
        bus1.addr_cache_to_ram_ctr = 1'b0;
        bus1.wb_addr               = 32'h0000_0100;
        bus1.refill_addr           = 32'h0000_0200;
        bus1.line_wdata            = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        @(posedge clk);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            e_en   = (k <= 4) || (k >= 7 && k <= 10);
            e_we   = (k <= 4);
            e_addr = (k <= 4) ? 32'h0000_0100 + 32'(4 * (k - 1)) :
                     e_en     ? 32'h0000_0200 + 32'(4 * (k - 7)) : 32'h0;
            e_wd   = (k <= 4) ? 32'hB0 + 32'(k - 1) : 32'h0;
            e_resp = (k == 5) || (k == 12);
            e_busy = (k <= 5) || (k >= 7 && k <= 12);
            if (bus1.response_ram_to_cache === 1'b1) resp_cnt++;
            nvec++;
            if ({bus1.ram_en, bus1.ram_we, bus1.ram_addr, bus1.ram_wdata,
                 bus1.response_ram_to_cache, bus1.bridge_busy} !==
                {e_en, e_we, e_addr, e_wd, e_resp, e_busy}) begin
                nerr++;
                $display("FAIL back_to_back c%0d: en=%b we=%b addr=%h wd=%h resp=%b busy=%b want en=%b we=%b addr=%h wd=%h resp=%b busy=%b",
                         k, bus1.ram_en, bus1.ram_we, bus1.ram_addr, bus1.ram_wdata,
                         bus1.response_ram_to_cache, bus1.bridge_busy,
                         e_en, e_we, e_addr, e_wd, e_resp, e_busy);
            end
            if (k == 5) begin
                bus1.write_cache_to_ram    = 1'b0;
                bus1.addr_cache_to_ram_ctr = 1'b1;
            end
            if (k == 12) bus1.enable_cache_to_ram = 1'b0;
        end
        nvec++;
        if (resp_cnt != 2) begin
            nerr++;
            $display("FAIL back_to_back_resp_count: got %0d want 2", resp_cnt);
        end
        nvec++;
        if (bus1.line_rdata !== {32'h0000_FDF3, 32'h0000_FDF7, 32'h0000_FDFB, 32'h0000_FDFF}) begin
            nerr++;
            $display("FAIL back_to_back_line: line_rdata=%h want 0000fdf30000fdf70000fdfb0000fdff",
                     bus1.line_rdata);
        end
    endtask

    task automatic test_lat3();
        logic        e_en;
        logic [31:0] e_addr;
        @(negedge clk);
        bus3.enable_cache_to_ram   = 1'b1;
        bus3.write_cache_to_ram    = 1'b0;
        bus3.addr_cache_to_ram_ctr = 1'b1;
        bus3.wb_addr               = 32'h0000_ABC0;
        bus3.refill_addr           = 32'h0000_3014;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            e_en   = (k <= 4);
            e_addr = e_en ? 32'h0000_3010 + 32'(4 * (k - 1)) : 32'h0;
            nvec++;
            if ({bus3.ram_en, bus3.ram_we, bus3.ram_addr,
                 bus3.response_ram_to_cache, bus3.bridge_busy} !==
                {e_en, 1'b0, e_addr, 1'(k == 8), 1'(k <= 8)}) begin
                nerr++;
                $display("FAIL lat3 c%0d: en=%b we=%b addr=%h resp=%b busy=%b want en=%b we=0 addr=%h resp=%b busy=%b",
                         k, bus3.ram_en, bus3.ram_we, bus3.ram_addr,
                         bus3.response_ram_to_cache, bus3.bridge_busy,
                         e_en, e_addr, 1'(k == 8), 1'(k <= 8));
            end
            if (k == 8) begin
                nvec++;
                if (bus3.line_rdata !== {32'h0000_CFE3, 32'h0000_CFE7, 32'h0000_CFEB, 32'h0000_CFEF}) begin
                    nerr++;
                    $display("FAIL lat3_line: line_rdata=%h want 0000cfe30000cfe70000cfeb0000cfef",
                             bus3.line_rdata);
                end
                bus3.enable_cache_to_ram = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        bus1.enable_cache_to_ram   = 1'b1;
        bus1.write_cache_to_ram    = 1'b1;
        bus1.addr_cache_to_ram_ctr = 1'b0;
        bus1.wb_addr               = 32'h0000_1234;
        bus1.line_wdata            = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        @(posedge clk);
        repeat (3) @(negedge clk);
        nvec++;
        if ({bus1.ram_en, bus1.ram_addr} !== {1'b1, 32'h0000_1238}) begin
            nerr++;
            $display("FAIL reset_mid_beat2: en=%b addr=%h want en=1 addr=00001238", bus1.ram_en, bus1.ram_addr);
        end
        rst = 1'b0;
        bus1.enable_cache_to_ram = 1'b0;
        #1;
        nvec++;
        if ({bus1.ram_en, bus1.response_ram_to_cache, bus1.bridge_busy} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_mid_async: en/resp/busy=%b want 000",
                     {bus1.ram_en, bus1.response_ram_to_cache, bus1.bridge_busy});
        end
        nvec++;
        if (bus1.line_rdata !== 128'h0) begin
            nerr++;
            $display("FAIL reset_mid_line: line_rdata=%h want 0", bus1.line_rdata);
        end
        repeat (2) @(negedge clk);
        nvec++;
        if ({bus1.ram_en, bus1.response_ram_to_cache, bus1.bridge_busy} !== 3'b000) begin
            nerr++;
            $display("FAIL reset_mid_hold: en/resp/busy=%b want 000",
                     {bus1.ram_en, bus1.response_ram_to_cache, bus1.bridge_busy});
        end
        rst = 1'b1;
        @(negedge clk);
        test_write_back();
    endtask

    task automatic test_enable_drop();
        logic        e_en;
        logic [31:0] e_addr;
        int          reads;
        int          resps;
        reads = 0;
        resps = 0;
        @(negedge clk);
        bus1.enable_cache_to_ram   = 1'b1;
        bus1.write_cache_to_ram    = 1'b0;
        bus1.addr_cache_to_ram_ctr = 1'b1;
        bus1.wb_addr               = 32'h0000_5550;
        bus1.refill_addr           = 32'h0000_4000;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 2) bus1.enable_cache_to_ram = 1'b0;
            if (bus1.ram_en === 1'b1 && bus1.ram_we === 1'b0) reads++;
            if (bus1.response_ram_to_cache === 1'b1) resps++;
            e_en   = (k <= 4);
            e_addr = e_en ? 32'h0000_4000 + 32'(4 * (k - 1)) : 32'h0;
            nvec++;
            if ({bus1.ram_en, bus1.ram_addr, bus1.response_ram_to_cache} !==
                {e_en, e_addr, 1'(k == 6)}) begin
                nerr++;
                $display("FAIL enable_drop c%0d: en=%b addr=%h resp=%b want en=%b addr=%h resp=%b",
                         k, bus1.ram_en, bus1.ram_addr, bus1.response_ram_to_cache,
                         e_en, e_addr, 1'(k == 6));
            end
        end
        nvec++;
        if (reads != 4 || resps != 1) begin
            nerr++;
            $display("FAIL enable_drop_counts: reads=%0d resps=%0d want reads=4 resps=1", reads, resps);
        end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_write_back();
        test_refill();
        test_back_to_back();
        test_lat3();
        test_reset_mid_burst();
        test_enable_drop();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
